// File: rtl/wb_stage_reg.sv
// MEM/WB pipeline register and writeback sequencer. Latches the writeback bundle,
// muxes link address on jal, and splits FP doubles into two register-file beats.
module wb_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int DBL_EN = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_in,
  input  logic                  flush_in,
  input  logic                  valid_in,
  input  logic                  regwritein,
  input  logic [REG_AW-1:0]     rwin,
  input  logic [2*DATA_W-1:0]   busWin,
  input  logic [1:0]            fpointin,
  input  logic [DATA_W-1:0]     delayslot2in,
  input  logic                  jalin,
  output logic [REG_AW-1:0]     rw,
  output logic [DATA_W-1:0]     busW,
  output logic                  regwr,
  output logic [1:0]            fpoint,
  output logic                  valid_out,
  output logic                  busy
);

  typedef enum logic {PASS, DBL2} state_t;

  localparam logic DBL_ON = (DBL_EN != 0);

  state_t                state, state_nx;
  logic                  valid_q, regwr_q, jal_q;
  logic [REG_AW-1:0]     rw_q;
  logic [2*DATA_W-1:0]   busw_q;
  logic [1:0]            fp_q;
  logic [DATA_W-1:0]     ds_q;
  logic                  dbl, capture;

  // A link write is always a single integer write, so jal suppresses the split.
  assign dbl = DBL_ON & valid_q & regwr_q & fp_q[1] & ~jal_q;

  always_comb begin
    state_nx  = state;
    capture   = 1'b0;
    rw        = rw_q;
    busW      = jal_q ? ds_q : busw_q[DATA_W-1:0];
    regwr     = valid_q & regwr_q;
    fpoint    = jal_q ? 2'b00 : {fp_q[1] & DBL_ON, fp_q[0]};
    valid_out = valid_q;
    busy      = 1'b0;
    case (state)
      PASS: begin
        if (dbl) begin
          rw   = {rw_q[REG_AW-1:1], 1'b0};
          busy = 1'b1;
        end
        if (!flush_in && !stall_in) begin
          if (dbl) state_nx = DBL2;
          else     capture  = 1'b1;
        end
      end
      DBL2: begin
        rw    = {rw_q[REG_AW-1:1], 1'b1};
        busW  = busw_q[2*DATA_W-1:DATA_W];
        regwr = 1'b1;
        if (!flush_in && !stall_in) begin
          state_nx = PASS;
          capture  = 1'b1;
        end
      end
      default: state_nx = PASS;
    endcase
    if (flush_in) state_nx = PASS;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= PASS;
      valid_q <= 1'b0;
      regwr_q <= 1'b0;
      jal_q   <= 1'b0;
      rw_q    <= '0;
      busw_q  <= '0;
      fp_q    <= '0;
      ds_q    <= '0;
    end else begin
      state <= state_nx;
      if (flush_in) begin
        valid_q <= 1'b0;
        regwr_q <= 1'b0;
        jal_q   <= 1'b0;
      end else if (capture) begin
        valid_q <= valid_in;
        regwr_q <= regwritein;
        jal_q   <= jalin;
        rw_q    <= rwin;
        busw_q  <= busWin;
        fp_q    <= fpointin;
        ds_q    <= delayslot2in;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage_reg.sv
// Directed bench for wb_stage_reg: single-cycle vector table plus hand sequences
// for double split, stall, flush and reset; a DBL_EN=0 copy checks the no-split build.
module tb_wb_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n, stall_in, flush_in, valid_in, regwritein, jalin;
  logic [4:0]  rwin;
  logic [63:0] busWin;
  logic [1:0]  fpointin;
  logic [31:0] delayslot2in;

  logic [4:0]  rw,  rw0;
  logic [31:0] busW, busW0;
  logic        regwr, regwr0, valid_out, valid_out0, busy, busy0;
  logic [1:0]  fpoint, fpoint0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_stage_reg #(.DATA_W(32), .REG_AW(5), .DBL_EN(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .flush_in(flush_in),
    .valid_in(valid_in), .regwritein(regwritein), .rwin(rwin), .busWin(busWin),
    .fpointin(fpointin), .delayslot2in(delayslot2in), .jalin(jalin),
    .rw(rw), .busW(busW), .regwr(regwr), .fpoint(fpoint),
    .valid_out(valid_out), .busy(busy));

  wb_stage_reg #(.DATA_W(32), .REG_AW(5), .DBL_EN(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .flush_in(flush_in),
    .valid_in(valid_in), .regwritein(regwritein), .rwin(rwin), .busWin(busWin),
    .fpointin(fpointin), .delayslot2in(delayslot2in), .jalin(jalin),
    .rw(rw0), .busW(busW0), .regwr(regwr0), .fpoint(fpoint0),
    .valid_out(valid_out0), .busy(busy0));

  typedef struct {
    logic        v, rwe, jal;
    logic [4:0]  rw;
    logic [63:0] bus;
    logic [1:0]  fp;
    logic [31:0] ds;
    logic [4:0]  e_rw;
    logic [31:0] e_bus;
    logic        e_regwr, e_valid, e_busy;
    logic [1:0]  e_fp;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rwe, input logic [4:0] r,
                       input logic [63:0] b, input logic [1:0] fp,
                       input logic [31:0] ds, input logic jal);
    valid_in = v; regwritein = rwe; rwin = r; busWin = b;
    fpointin = fp; delayslot2in = ds; jalin = jal;
  endtask

  task automatic chk_out(input string tag, input logic [4:0] e_rw, input logic [31:0] e_bus,
                         input logic e_regwr, input logic e_busy);
    chk({tag, ".rw"},    rw,    e_rw);
    chk({tag, ".busW"},  busW,  e_bus);
    chk({tag, ".regwr"}, regwr, e_regwr);
    chk({tag, ".busy"},  busy,  e_busy);
  endtask

  localparam logic [63:0] DBLW = 64'hAAAA_AAAA_5555_5555;

  initial begin
    //          v    rwe  jal  rw     bus                     fp     ds             e_rw   e_bus          e_rw e_v  e_b  e_fp
    vt[0] = '{1'b1, 1'b1, 1'b0, 5'd7,  64'h0000_0000_1234_5678, 2'b00, 32'h0,         5'd7,  32'h1234_5678, 1'b1, 1'b1, 1'b0, 2'b00};
    vt[1] = '{1'b1, 1'b1, 1'b1, 5'd31, 64'h0000_0000_0000_DEAD, 2'b10, 32'h0040_0108, 5'd31, 32'h0040_0108, 1'b1, 1'b1, 1'b0, 2'b00};
    vt[2] = '{1'b1, 1'b1, 1'b0, 5'd9,  64'hFFFF_0000_CAFE_BABE, 2'b01, 32'h0,         5'd9,  32'hCAFE_BABE, 1'b1, 1'b1, 1'b0, 2'b01};
    vt[3] = '{1'b0, 1'b1, 1'b0, 5'd3,  64'h0000_0000_0000_0011, 2'b00, 32'h0,         5'd3,  32'h0000_0011, 1'b0, 1'b0, 1'b0, 2'b00};
    vt[4] = '{1'b1, 1'b0, 1'b0, 5'd5,  64'h1111_2222_3333_4444, 2'b11, 32'h0,         5'd5,  32'h3333_4444, 1'b0, 1'b1, 1'b0, 2'b11};
    vt[5] = '{1'b1, 1'b1, 1'b1, 5'd31, DBLW,                    2'b11, 32'h0040_0200, 5'd31, 32'h0040_0200, 1'b1, 1'b1, 1'b0, 2'b00};

    rst_n = 1'b0; stall_in = 1'b0; flush_in = 1'b0;
    drive(1'b1, 1'b1, 5'd21, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 32'hFFFF_FFFF, 1'b0);
    tick(); tick();
    chk_out("reset", 5'd0, 32'h0, 1'b0, 1'b0);
    chk("reset.fpoint", fpoint, 2'b00);
    chk("reset.valid",  valid_out, 1'b0);

    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(vt[i].v, vt[i].rwe, vt[i].rw, vt[i].bus, vt[i].fp, vt[i].ds, vt[i].jal);
      tick();
      chk_out($sformatf("vec%0d", i), vt[i].e_rw, vt[i].e_bus, vt[i].e_regwr, vt[i].e_busy);
      chk($sformatf("vec%0d.fpoint", i), fpoint, vt[i].e_fp);
      chk($sformatf("vec%0d.valid", i), valid_out, vt[i].e_valid);
    end

    // Double split; the bundle offered during beat 1 lands after beat 2.
    drive(1'b1, 1'b1, 5'd5, DBLW, 2'b11, 32'h0, 1'b0);
    tick();
    chk_out("dbl.b1", 5'd4, 32'h5555_5555, 1'b1, 1'b1);
    chk("dbl.b1.fpoint", fpoint, 2'b11);
    drive(1'b1, 1'b1, 5'd12, 64'h777, 2'b00, 32'h0, 1'b0);
    tick();
    chk_out("dbl.b2", 5'd5, 32'hAAAA_AAAA, 1'b1, 1'b0);
    tick();
    chk_out("dbl.next", 5'd12, 32'h0000_0777, 1'b1, 1'b0);

    // Stall held three cycles in DBL2.
    drive(1'b1, 1'b1, 5'd5, DBLW, 2'b11, 32'h0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 5'd12, 64'h777, 2'b00, 32'h0, 1'b0);
    tick();
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("stall%0d", i), 5'd5, 32'hAAAA_AAAA, 1'b1, 1'b0);
    end
    stall_in = 1'b0;
    tick();
    chk_out("stall.resume", 5'd12, 32'h0000_0777, 1'b1, 1'b0);

    // Flush during beat 1, then flush together with stall.
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b1, 5'd5, DBLW, 2'b11, 32'h0, 1'b0);
      tick();
      chk($sformatf("flush%0d.pre_busy", k), busy, 1'b1);
      flush_in = 1'b1;
      stall_in = (k == 1);
      drive(1'b0, 1'b0, 5'd0, 64'h0, 2'b00, 32'h0, 1'b0);
      tick();
      flush_in = 1'b0; stall_in = 1'b0;
      chk($sformatf("flush%0d.valid", k), valid_out, 1'b0);
      chk($sformatf("flush%0d.regwr", k), regwr, 1'b0);
      chk($sformatf("flush%0d.busy", k), busy, 1'b0);
      tick();
      chk($sformatf("flush%0d.nobeat2", k), regwr, 1'b0);
    end

    // Reset during DBL2, then no-split build handles the same double as a single write.
    drive(1'b1, 1'b1, 5'd5, DBLW, 2'b11, 32'h0, 1'b0);
    tick(); tick();
    chk("rst.pre_rw", rw, 5'd5);
    rst_n = 1'b0;
    tick();
    chk_out("rstdbl", 5'd0, 32'h0, 1'b0, 1'b0);
    chk("rstdbl.fpoint", fpoint, 2'b00);
    chk("rstdbl.valid", valid_out, 1'b0);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 5'd5, DBLW, 2'b11, 32'h0, 1'b0);
    tick();
    chk("nodbl.rw",    rw0,    5'd5);
    chk("nodbl.busW",  busW0,  32'h5555_5555);
    chk("nodbl.regwr", regwr0, 1'b1);
    chk("nodbl.busy",  busy0,  1'b0);
    chk("rst.restart_busy", busy, 1'b1);
    chk("rst.restart_rw",   rw,   5'd4);
    drive(1'b0, 1'b0, 5'd0, 64'h0, 2'b00, 32'h0, 1'b0);
    tick();
    chk("nodbl.no_beat2", regwr0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
